// File: rtl/program_sequencer.sv
// Steps a loadable opcode memory into control_unit: one FETCH/ISSUE/RETIRE triple per instruction.
// All outputs registered from the next state; INPUT stalls in WAIT_IN until in_valid, stop aborts cleanly.
module program_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [3:0]        prog_data,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              in_ack,
  output logic [3:0]        opcode,
  output logic              ex_btn,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_IN, S_ISSUE, S_RETIRE, S_PAUSE, S_DONE, S_ERROR
  } state_t;

  localparam logic [3:0]        OP_NOP   = 4'b0000;
  localparam logic [3:0]        OP_INPUT = 4'b0001;
  localparam logic [3:0]        OP_HALT  = 4'b1111;
  localparam logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        instr_q, instr_d;
  logic              step_mode_q, step_mode_d;
  logic              stop_pend_q, stop_pend_d;
  logic [3:0]        mem_q [DEPTH];
  logic [3:0]        mem_d [DEPTH];
  logic [3:0]        opcode_q, opcode_d;
  logic              ex_btn_q, ex_btn_d;
  logic              in_ready_q, in_ready_d;
  logic              in_ack_q, in_ack_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic       parked;
  logic [3:0] fetched;

  assign parked  = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
  assign fetched = mem_q[pc_q];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    step_mode_d = step_mode_q;
    stop_pend_d = stop_pend_q;
    mem_d       = mem_q;

    // Program memory is frozen while a program is running.
    if (prog_we && parked) begin
      mem_d[prog_addr] = prog_data;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          pc_d        = '0;
          step_mode_d = step_mode;
          stop_pend_d = 1'b0;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        instr_d = fetched;
        if (stop) begin
          state_d = S_IDLE;
        end else if (fetched == OP_HALT) begin
          state_d = S_DONE;
        end else if (fetched inside {[4'b1100:4'b1110]}) begin
          state_d = S_ERROR;
        end else if ((fetched == OP_INPUT) && !in_valid) begin
          state_d = S_WAIT_IN;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT_IN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (in_valid) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The write-enable pulse must still be closed by RETIRE, so stop only takes effect after it.
        stop_pend_d = stop;
        state_d     = S_RETIRE;
      end
      S_RETIRE: begin
        stop_pend_d = 1'b0;
        if (stop_pend_q || stop) begin
          state_d = S_IDLE;
        end else if (pc_q == PC_LAST) begin
          state_d = S_DONE;
        end else if (step_mode_q) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_PAUSE;
        end else begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (step) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs describe the state being entered so they can be registered.
    opcode_d   = (state_d == S_ISSUE) ? instr_d : OP_NOP;
    ex_btn_d   = !((state_d == S_ISSUE) || (state_d == S_RETIRE));
    in_ready_d = (state_d == S_WAIT_IN);
    in_ack_d   = (state_d == S_RETIRE) && (instr_d == OP_INPUT);
    busy_d     = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      instr_q     <= OP_NOP;
      step_mode_q <= 1'b0;
      stop_pend_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= OP_HALT;
      end
      opcode_q    <= OP_NOP;
      ex_btn_q    <= 1'b1;
      in_ready_q  <= 1'b0;
      in_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      step_mode_q <= step_mode_d;
      stop_pend_q <= stop_pend_d;
      mem_q       <= mem_d;
      opcode_q    <= opcode_d;
      ex_btn_q    <= ex_btn_d;
      in_ready_q  <= in_ready_d;
      in_ack_q    <= in_ack_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign opcode   = opcode_q;
  assign ex_btn   = ex_btn_q;
  assign pc       = pc_q;
  assign in_ready = in_ready_q;
  assign in_ack   = in_ack_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Cycle-accurate vector bench for program_sequencer: each row drives one cycle of inputs and
// queues the outputs expected after the next rising edge.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [3:0] prog_data;
  logic       start, step_mode, step, stop, in_valid;
  logic       in_ready, in_ack, ex_btn, busy, done, err;
  logic [3:0] opcode;
  logic [3:0] pc;

  always #5 clk = ~clk;

  program_sequencer #(.DEPTH(16)) dut (
    .clk(clk), .rstn(rstn),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .step_mode(step_mode), .step(step), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .in_ack(in_ack),
    .opcode(opcode), .ex_btn(ex_btn), .pc(pc),
    .busy(busy), .done(done), .err(err)
  );

  // {opcode, ex_btn, pc, in_ready, in_ack, busy, done, err}
  logic [13:0] obs;
  assign obs = {opcode, ex_btn, pc, in_ready, in_ack, busy, done, err};

  typedef struct packed {
    logic [4:0]  ins;   // {start, step_mode, step, stop, in_valid}
    logic        we;
    logic [3:0]  wa;
    logic [3:0]  wd;
    logic [13:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [13:0] sb_exp[$];
  string       sb_tag[$];
  int          nerr = 0;
  int          nchk = 0;

  function automatic logic [13:0] o(logic [3:0] op, bit exb, logic [3:0] p,
                                    bit rdy, bit ack, bit bsy, bit dn, bit er);
    return {op, exb, p, rdy, ack, bsy, dn, er};
  endfunction

  function automatic logic [13:0] f_idle(logic [3:0] p);  return o(4'h0, 1, p, 0, 0, 0, 0, 0); endfunction
  function automatic logic [13:0] f_fetch(logic [3:0] p); return o(4'h0, 1, p, 0, 0, 1, 0, 0); endfunction
  function automatic logic [13:0] f_pause(logic [3:0] p); return o(4'h0, 1, p, 0, 0, 1, 0, 0); endfunction
  function automatic logic [13:0] f_wait(logic [3:0] p);  return o(4'h0, 1, p, 1, 0, 1, 0, 0); endfunction
  function automatic logic [13:0] f_issue(logic [3:0] op, logic [3:0] p); return o(op, 0, p, 0, 0, 1, 0, 0); endfunction
  function automatic logic [13:0] f_retire(logic [3:0] p, bit ack); return o(4'h0, 0, p, 0, ack, 1, 0, 0); endfunction
  function automatic logic [13:0] f_done(logic [3:0] p);  return o(4'h0, 1, p, 0, 0, 0, 1, 0); endfunction
  function automatic logic [13:0] f_err(logic [3:0] p);   return o(4'h0, 1, p, 0, 0, 0, 0, 1); endfunction

  function automatic logic [4:0] in_v(bit st, bit sm, bit stp, bit sp, bit iv);
    return {st, sm, stp, sp, iv};
  endfunction

  function automatic void addvw(logic [4:0] ins, bit we, logic [3:0] wa, logic [3:0] wd, logic [13:0] e);
    vec_t v;
    v.ins = ins; v.we = we; v.wa = wa; v.wd = wd; v.exp = e;
    tbl.push_back(v);
  endfunction

  function automatic void addv(logic [4:0] ins, logic [13:0] e);
    addvw(ins, 1'b0, 4'h0, 4'h0, e);
  endfunction

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got op=%h exb=%b pc=%0d rdy=%b ack=%b busy=%b done=%b err=%b, expected op=%h exb=%b pc=%0d rdy=%b ack=%b busy=%b done=%b err=%b",
               name, act[13:10], act[9], act[8:5], act[4], act[3], act[2], act[1], act[0],
               exp[13:10], exp[9], exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic idle_inputs();
    {start, step_mode, step, stop, in_valid} = 5'b0;
    prog_we = 1'b0; prog_addr = 4'h0; prog_data = 4'h0;
  endtask

  // Called at posedge+1: drives one row, then compares after the edge that samples it.
  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      {start, step_mode, step, stop, in_valid} = tbl[i].ins;
      prog_we = tbl[i].we; prog_addr = tbl[i].wa; prog_data = tbl[i].wd;
      sb_exp.push_back(tbl[i].exp);
      sb_tag.push_back($sformatf("%s[%0d]", name, i));
      @(posedge clk); #1;
      chk(sb_tag.pop_front(), obs, sb_exp.pop_front());
    end
    idle_inputs();
    tbl.delete();
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  initial begin
    idle_inputs();
    do_reset();
    chk("reset_state", obs, f_idle(4'd0));

    // Asynchronous reset in the middle of ISSUE, then memory must read back as HALT.
    load(4'd0, 4'b0110);
    addv(in_v(1, 0, 0, 0, 0), f_fetch(4'd0));
    addv(in_v(0, 0, 0, 0, 0), f_issue(4'b0110, 4'd0));
    run_tbl("pre_reset");
    #2 rstn = 1'b0;
    #1 chk("async_reset_mid_issue", obs, f_idle(4'd0));
    #2 rstn = 1'b1;
    @(posedge clk); #1;
    addv(in_v(1, 0, 0, 0, 0), f_fetch(4'd0));
    addv(in_v(0, 0, 0, 0, 0), f_done(4'd0));
    run_tbl("unwritten_halt");

    // Run mode: {0110, 0010, HALT}.
    do_reset();
    load(4'd0, 4'b0110);
    load(4'd1, 4'b0010);
    addv(in_v(1, 0, 0, 0, 0), f_fetch(4'd0));
    addv(in_v(0, 0, 0, 0, 0), f_issue(4'b0110, 4'd0));
    addv(in_v(0, 0, 0, 0, 0), f_retire(4'd0, 0));
    addv(in_v(0, 0, 0, 0, 0), f_fetch(4'd1));
    addv(in_v(0, 0, 0, 0, 0), f_issue(4'b0010, 4'd1));
    addv(in_v(0, 0, 0, 0, 0), f_retire(4'd1, 0));
    addv(in_v(0, 0, 0, 0, 0), f_fetch(4'd2));
    addv(in_v(0, 0, 0, 0, 0), f_done(4'd2));
    addv(in_v(0, 0, 0, 0, 0), f_done(4'd2));
    run_tbl("run");

    // INPUT with in_valid low for five cycles, then with in_valid already high.
    do_reset();
    load(4'd0, 4'b0001);
    addv(in_v(1, 0, 0, 0, 0), f_fetch(4'd0));
    for (int i = 0; i < 5; i++) addv(in_v(0, 0, 0, 0, 0), f_wait(4'd0));
    addv(in_v(0, 0, 0, 0, 1), f_issue(4'b0001, 4'd0));
    addv(in_v(0, 0, 0, 0, 1), f_retire(4'd0, 1));
    addv(in_v(0, 0, 0, 0, 0), f_fetch(4'd1));
    addv(in_v(0, 0, 0, 0, 0), f_done(4'd1));
    addv(in_v(1, 0, 0, 0, 1), f_fetch(4'd0));
    addv(in_v(0, 0, 0, 0, 1), f_issue(4'b0001, 4'd0));
    addv(in_v(0, 0, 0, 0, 1), f_retire(4'd0, 1));
    addv(in_v(0, 0, 0, 0, 0), f_fetch(4'd1));
    addv(in_v(0, 0, 0, 0, 0), f_done(4'd1));
    run_tbl("input_wait");

    // Single-step over {0011, 0100, 0101}.
    do_reset();
    load(4'd0, 4'b0011);
    load(4'd1, 4'b0100);
    load(4'd2, 4'b0101);
    addv(in_v(1, 1, 0, 0, 0), f_fetch(4'd0));
    addv(in_v(0, 0, 0, 0, 0), f_issue(4'b0011, 4'd0));
    addv(in_v(0, 0, 0, 0, 0), f_retire(4'd0, 0));
    addv(in_v(0, 0, 0, 0, 0), f_pause(4'd1));
    addv(in_v(0, 0, 0, 0, 0), f_pause(4'd1));
    addv(in_v(0, 0, 1, 0, 0), f_fetch(4'd1));
    addv(in_v(0, 0, 0, 0, 0), f_issue(4'b0100, 4'd1));
    addv(in_v(0, 0, 0, 0, 0), f_retire(4'd1, 0));
    addv(in_v(0, 0, 0, 0, 0), f_pause(4'd2));
    addv(in_v(0, 0, 1, 0, 0), f_fetch(4'd2));
    addv(in_v(0, 0, 0, 0, 0), f_issue(4'b0101, 4'd2));
    addv(in_v(0, 0, 0, 0, 0), f_retire(4'd2, 0));
    addv(in_v(0, 0, 0, 0, 0), f_pause(4'd3));
    addv(in_v(0, 0, 1, 0, 0), f_fetch(4'd3));
    addv(in_v(0, 0, 0, 0, 0), f_done(4'd3));
    run_tbl("single_step");

    // Illegal opcode at address 1.
    do_reset();
    load(4'd0, 4'b0000);
    load(4'd1, 4'b1101);
    addv(in_v(1, 0, 0, 0, 0), f_fetch(4'd0));
    addv(in_v(0, 0, 0, 0, 0), f_issue(4'b0000, 4'd0));
    addv(in_v(0, 0, 0, 0, 0), f_retire(4'd0, 0));
    addv(in_v(0, 0, 0, 0, 0), f_fetch(4'd1));
    addv(in_v(0, 0, 0, 0, 0), f_err(4'd1));
    addv(in_v(0, 0, 0, 0, 0), f_err(4'd1));
    run_tbl("illegal");

    // Every entry a NOP: sixteen issues, finishing at the last address.
    do_reset();
    for (int i = 0; i < 16; i++) load(4'(i), 4'b0000);
    addv(in_v(1, 0, 0, 0, 0), f_fetch(4'd0));
    for (int i = 0; i < 16; i++) begin
      addv(in_v(0, 0, 0, 0, 0), f_issue(4'b0000, 4'(i)));
      addv(in_v(0, 0, 0, 0, 0), f_retire(4'(i), 0));
      if (i < 15) addv(in_v(0, 0, 0, 0, 0), f_fetch(4'(i + 1)));
      else        addv(in_v(0, 0, 0, 0, 0), f_done(4'd15));
    end
    run_tbl("full_depth");

    // Stop in ISSUE, start+stop in IDLE, stop+step in PAUSE, stop in FETCH.
    do_reset();
    load(4'd0, 4'b0111);
    load(4'd1, 4'b0111);
    addv(in_v(1, 0, 0, 0, 0), f_fetch(4'd0));
    addv(in_v(0, 0, 0, 0, 0), f_issue(4'b0111, 4'd0));
    addv(in_v(0, 0, 0, 1, 0), f_retire(4'd0, 0));
    addv(in_v(0, 0, 0, 0, 0), f_idle(4'd0));
    addv(in_v(1, 1, 0, 1, 0), f_fetch(4'd0));
    addv(in_v(0, 0, 0, 0, 0), f_issue(4'b0111, 4'd0));
    addv(in_v(0, 0, 0, 0, 0), f_retire(4'd0, 0));
    addv(in_v(0, 0, 0, 0, 0), f_pause(4'd1));
    addv(in_v(0, 0, 1, 1, 0), f_idle(4'd1));
    addv(in_v(1, 0, 0, 0, 0), f_fetch(4'd0));
    addv(in_v(0, 0, 0, 1, 0), f_idle(4'd0));
    run_tbl("stop");

    // Write to address 1 while busy must be dropped; an accepted write would trap as illegal.
    do_reset();
    load(4'd0, 4'b0010);
    addv(in_v(1, 0, 0, 0, 0), f_fetch(4'd0));
    addvw(in_v(0, 0, 0, 0, 0), 1'b1, 4'd1, 4'b1101, f_issue(4'b0010, 4'd0));
    addvw(in_v(0, 0, 0, 0, 0), 1'b1, 4'd1, 4'b1101, f_retire(4'd0, 0));
    addv(in_v(0, 0, 0, 0, 0), f_fetch(4'd1));
    addv(in_v(0, 0, 0, 0, 0), f_done(4'd1));
    run_tbl("write_protect");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
